serial_sub_fsm: RTL and testbench
=================================

// Module: serial_sub_fsm
// PURPOSE
//  Bit-serial WIDTH-bit subtractor, LSB first. Computes a - b - bin.
//  Per-bit datapath is the 1-bit full-subtractor cell (diff/borrow);
//  this block supplies its operand stream and holds its borrow in a flop.
//  start/busy/done handshake feeds results to downstream logic.
//  Latency: WIDTH cycles per operation.
// PARAMETERS
//  WIDTH  8  operand/result width in bits, >= 1
// PORTS
//  clk     in   1      clock, all state updates on rising edge
//  rst_n   in   1      synchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  minuend, captured when start accepted
//  b       in   WIDTH  subtrahend, captured when start accepted
//  bin     in   1      borrow-in, captured when start accepted
//  diff    out  WIDTH  result a-b-bin mod 2^WIDTH, held until next done
//  borrow  out  1      borrow-out of MSB (1 when a < b+bin)
//  busy    out  1      high in RUN and DONE states
//  done    out  1      one-cycle pulse, diff/borrow valid and updated
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; diff=0, borrow=0, busy=0, done=0.
//   Internal shift regs, counter and borrow flop cleared to 0.
//   Reset wins over every other event, including mid-RUN; partial
//   result is discarded and diff/borrow read 0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: busy=0, done=0. start=1 at edge: load sa<=a, sb<=b, br<=bin,
//   cnt<=0, go RUN. start=0: stay.
//  RUN (one edge per bit, WIDTH edges):
//   d   = sa[0] ^ sb[0] ^ br
//   bo  = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br)
//   sa, sb shift right by 1; sd shifts right with d entering MSB;
//   br <= bo; cnt <= cnt+1.
//   On edge with cnt==WIDTH-1: diff <= {d, sd[WIDTH-1:1]},
//   borrow <= bo, go DONE. (For WIDTH=1, diff <= d.)
//  DONE: done=1 for exactly this cycle, busy=1; next edge -> IDLE.
//  Timing: start accepted at edge E; done high during cycle after
//   edge E+WIDTH; next start accepted no earlier than edge E+WIDTH+2.
//  start while busy (RUN or DONE): ignored, no queuing, no effect.
//  a/b/bin changes after capture: no effect on current operation.
//  diff/borrow change only at completion edge (or reset); stable
//   during RUN, holding previous result.
//  cnt width = max(1, clog2(WIDTH)); wraps unused.
//  Unsigned arithmetic; no overflow flag beyond borrow.
// TESTING (WIDTH=8 unless noted)
//  a=200,b=55,bin=0,start -> after 8 edges done=1, diff=145, borrow=0.
//  a=55,b=200,bin=0 -> diff=111, borrow=1; a=0,b=0,bin=1 -> diff=255,
//   borrow=1; a=0xFF,b=0xFF,bin=0 -> diff=0, borrow=0.
//  start pulse held high in RUN with new a=1,b=1 -> ignored; first
//   result unchanged; done pulses exactly once, busy=1 for 9 cycles.
//  rst_n=0 at bit 4 of a=200,b=55 -> next cycle state IDLE, busy=0,
//   done=0, diff=0, borrow=0; new start after release gives correct.
//  Back-to-back: start held high continuously -> ops accepted every
//   10 cycles; diff stable between done pulses.
//  WIDTH=1 exhaustive a,b,bin in {0,1} -> diff/borrow match
//   full-subtractor truth table, done 1 edge after accept.

Source files
------------

// File: rtl/serial_sub_fsm.sv
// Bit-serial subtractor computing a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is fed from operand shift registers; its
// borrow is carried between bits in a flop. start/busy/done handshake.
module serial_sub_fsm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sb_q;
    logic              br_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  diff_q;
    logic              borrow_q;

    logic              accept;
    logic              last_bit;
    logic              bit_d;
    logic              bit_bo;
    logic [WIDTH-1:0]  result;

    // Full-subtractor cell on the current LSBs plus the carried borrow
    always_comb begin
        bit_d    = sa_q[0] ^ sb_q[0] ^ br_q;
        bit_bo   = (~sa_q[0] & sb_q[0]) | (~sa_q[0] & br_q) | (sb_q[0] & br_q);
        accept   = (state_q == StIdle) && start;
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    // Result assembly: earlier bits sit in the partial-difference register
    if (WIDTH > 1) begin : g_multi
        logic [WIDTH-2:0] sd_q;

        // Partial difference shifts right, newest bit entering at the top
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sd_q <= '0;
            end else if (accept) begin
                sd_q <= '0;
            end else if (state_q == StRun) begin
                sd_q <= (sd_q >> 1) | ((WIDTH-1)'(bit_d) << (WIDTH - 2));
            end
        end

        assign result = {bit_d, sd_q};
    end else begin : g_single
        assign result = bit_d;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (last_bit) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand capture, per-bit shifting, borrow and bit counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_q  <= '0;
            sb_q  <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            sa_q  <= a;
            sb_q  <= b;
            br_q  <= bin;
            cnt_q <= '0;
        end else if (state_q == StRun) begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            br_q  <= bit_bo;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Published result changes only on the final bit (or reset)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (state_q == StRun && last_bit) begin
            diff_q   <= result;
            borrow_q <= bit_bo;
        end
    end

    // Output decode
    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        diff   = diff_q;
        borrow = borrow_q;
    end

endmodule

// File: tb/tb_serial_sub_fsm.sv
module tb_serial_sub_fsm;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow, busy, done;

    logic       start1;
    logic [0:0] a1, b1;
    logic       bin1;
    logic [0:0] diff1;
    logic       borrow1, busy1, done1;

    int   checks;
    int   errors;
    exp_t sbq[$];
    logic [1:0] sbq1[$];
    logic [7:0] mdl_diff;
    logic       mdl_borrow;

    serial_sub_fsm #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .diff(diff), .borrow(borrow), .busy(busy), .done(done)
    );

    serial_sub_fsm #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .diff(diff1), .borrow(borrow1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    function automatic exp_t model8(input logic [7:0] av, bv, input logic binv);
        logic [8:0] r;
        exp_t e;
        r = {1'b0, av} - {1'b0, bv} - {8'd0, binv};
        e.diff = r[7:0];
        e.borrow = r[8];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({diff, borrow, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: got diff=%0d borrow=%b busy=%b done=%b, want all 0",
                     diff, borrow, busy, done);
        end
        checks++;
        if ({diff1, borrow1, busy1, done1} !== 4'd0) begin
            errors++;
            $display("FAIL reset1: got diff=%0d borrow=%b busy=%b done=%b, want all 0",
                     diff1, borrow1, busy1, done1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
        mdl_diff = '0;
        mdl_borrow = 1'b0;
    endtask

    // One operation on the 8-bit instance; inputs are scrambled after capture
    task automatic run_op(input logic [7:0] av, bv, input logic binv);
        exp_t e;
        int lat;
        sbq.push_back(model8(av, bv, binv));
        a = av; b = bv; bin = binv; start = 1'b1;
        tick();
        start = 1'b0; a = ~av; b = ~bv; bin = ~binv;
        lat = 1;
        while (done !== 1'b1 && lat <= 20) begin
            checks++;
            if (busy !== 1'b1 || diff !== mdl_diff || borrow !== mdl_borrow) begin
                errors++;
                $display("FAIL run_hold: busy=%b diff=%0d borrow=%b, want 1 %0d %b",
                         busy, diff, borrow, mdl_diff, mdl_borrow);
            end
            tick();
            lat++;
        end
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL latency: done at cycle %0d, want 9", lat);
        end
        e = (sbq.size() > 0) ? sbq.pop_front() : '0;
        checks++;
        if (diff !== e.diff || borrow !== e.borrow || busy !== 1'b1) begin
            errors++;
            $display("FAIL result %0d-%0d-%0d: diff=%0d borrow=%b busy=%b, want %0d %b 1",
                     av, bv, binv, diff, borrow, busy, e.diff, e.borrow);
        end
        mdl_diff = e.diff;
        mdl_borrow = e.borrow;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b after done, want 0 0", done, busy);
        end
    endtask

    task automatic test_vectors();
        run_op(8'd200, 8'd55, 1'b0);
        run_op(8'd55, 8'd200, 1'b0);
        run_op(8'd0, 8'd0, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b0);
        run_op(8'h5A, 8'h3C, 1'b1);
    endtask

    task automatic test_start_ignored();
        int busy_cnt;
        int done_cnt;
        exp_t e;
        e = model8(8'd200, 8'd55, 1'b0);
        a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
        tick();
        a = 8'd1; b = 8'd1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                start = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        checks++;
        if (busy_cnt != 9) begin
            errors++;
            $display("FAIL ignore_busy_len: busy for %0d cycles, want 9", busy_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL ignore_done_cnt: %0d done pulses, want 1", done_cnt);
        end
        checks++;
        if (diff !== e.diff || borrow !== e.borrow) begin
            errors++;
            $display("FAIL ignore_result: diff=%0d borrow=%b, want %0d %b",
                     diff, borrow, e.diff, e.borrow);
        end
        mdl_diff = e.diff;
        mdl_borrow = e.borrow;
    endtask

    task automatic test_reset_mid_run();
        a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
        sbq.push_back(model8(8'd200, 8'd55, 1'b0));
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        sbq.delete();
        mdl_diff = '0;
        mdl_borrow = 1'b0;
        checks++;
        if ({diff, borrow, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: diff=%0d borrow=%b busy=%b done=%b, want all 0",
                     diff, borrow, busy, done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || diff !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_hold: busy=%b diff=%0d, want 0 0", busy, diff);
        end
        run_op(8'd200, 8'd55, 1'b0);
    endtask

    // start held high: accepts every 10 cycles, inputs vary every cycle
    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] av, bv;
        start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            av = 8'(n * 37 + 11);
            bv = 8'(n * 91 + 5);
            a = av; b = bv; bin = n[1];
            if (n % 10 == 0) sbq.push_back(model8(av, bv, n[1]));
            if (n == 39) start = 1'b0;
            tick();
            checks++;
            if (done !== (n % 10 == 8)) begin
                errors++;
                $display("FAIL b2b_done n=%0d: done=%b, want %b", n, done, (n % 10 == 8));
            end
            if (n % 10 == 8) begin
                e = (sbq.size() > 0) ? sbq.pop_front() : '0;
                mdl_diff = e.diff;
                mdl_borrow = e.borrow;
            end
            checks++;
            if (diff !== mdl_diff || borrow !== mdl_borrow) begin
                errors++;
                $display("FAIL b2b_result n=%0d: diff=%0d borrow=%b, want %0d %b",
                         n, diff, borrow, mdl_diff, mdl_borrow);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b pending=%0d, want 0 0", busy, sbq.size());
        end
    endtask

    task automatic test_width1();
        logic [1:0] r;
        logic [1:0] e;
        int lat;
        for (int v = 0; v < 8; v++) begin
            r = {1'b0, v[2]} - {1'b0, v[1]} - {1'b0, v[0]};
            sbq1.push_back(r);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            lat = 1;
            while (done1 !== 1'b1 && lat <= 5) begin
                tick();
                lat++;
            end
            e = (sbq1.size() > 0) ? sbq1.pop_front() : 2'b00;
            checks++;
            if (lat != 2 || diff1 !== e[0] || borrow1 !== e[1]) begin
                errors++;
                $display("FAIL w1 a=%0d b=%0d bin=%0d: lat=%0d diff=%b borrow=%b, want 2 %b %b",
                         v[2], v[1], v[0], lat, diff1, borrow1, e[0], e[1]);
            end
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        mdl_diff = '0;
        mdl_borrow = 1'b0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
